// File: rtl/ccff_chain_loader.sv
// Writer side of the ccff configuration-chain interface: streams NUM_CHAINS-wide beats into the fabric chains.
// Define CCFF_READBACK_EN to add a second VERIFY pass that checks ccff_tail against the re-streamed bitstream.
module ccff_chain_loader #(
  parameter int unsigned NUM_CHAINS = 10,
  parameter int unsigned CHAIN_LEN  = 1024,
  parameter int unsigned CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  global_resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NUM_CHAINS-1:0] s_data,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  ccff_shift,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
`ifdef CCFF_READBACK_EN
    VERIFY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic             beat;

  always_comb begin
    state_d = state;
    count_d = count;
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    beat    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
`ifdef CCFF_READBACK_EN
      LOAD, VERIFY: begin
`else
      LOAD: begin
`endif
        s_ready = 1'b1;
        busy    = 1'b1;
        beat    = s_valid && !abort;
        if (beat) begin
          if (count == CNT_W'(CHAIN_LEN - 1)) begin
            count_d = '0;
`ifdef CCFF_READBACK_EN
            state_d = (state == LOAD) ? VERIFY : DONE;
`else
            state_d = DONE;
`endif
          end else begin
            count_d = count + 1'b1;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state      <= IDLE;
      count      <= '0;
      ccff_head  <= '0;
      ccff_shift <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      ccff_shift <= beat;
      if (beat) ccff_head <= s_data;
    end
  end

`ifdef CCFF_READBACK_EN
  logic verify_shift;
  logic error_q;
  logic start_ok;

  assign start_ok = start && !abort && (state == IDLE || state == DONE);

  // Tag strobes that come from VERIFY beats: the final LOAD strobe lands in VERIFY
  // and the final VERIFY strobe lands in DONE, so state alone cannot select them.
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      verify_shift <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      verify_shift <= beat && (state == VERIFY);
      if (start_ok)
        error_q <= 1'b0;
      else if (ccff_shift && verify_shift && (ccff_tail != ccff_head))
        error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_tail;
  assign unused_tail = ^ccff_tail;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader against a pass/index level model of the load sequence
// plus a shift-register model of the fabric chains.
module tb_ccff_chain_loader;
  localparam int unsigned NC  = 10;
  localparam int unsigned LEN = 8;
`ifdef CCFF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          global_resetn;
  logic          start, abort, s_valid, s_ready;
  logic [NC-1:0] s_data, ccff_head, ccff_tail;
  logic          ccff_shift, busy, done, error;

  ccff_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(LEN)) dut (
    .clk(clk), .global_resetn(global_resetn), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ccff_head(ccff_head), .ccff_shift(ccff_shift), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Fabric: one LEN-deep shift register per chain, shifting on strobed edges.
  logic [NC-1:0] fab [LEN];
  initial for (int i = 0; i < LEN; i++) fab[i] = '0;
  always @(posedge clk) begin
    if (ccff_shift) begin
      for (int i = LEN - 1; i > 0; i--) fab[i] <= fab[i-1];
      fab[0] <= ccff_head;
    end
  end
  assign ccff_tail = fab[LEN-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which pass we are in, how many beats of it were taken, and the first-pass bitstream.
  bit            m_busy, m_done, m_shift, m_err, m_err_pend;
  int            m_pass, m_idx;
  logic [NC-1:0] m_head;
  logic [NC-1:0] m_first [LEN];

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_shift = 0; m_err = 0; m_err_pend = 0;
    m_pass = 0; m_idx = 0; m_head = '0;
  endtask

  task automatic check_all();
    check("s_ready", 32'(s_ready), 32'(m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("ccff_shift", 32'(ccff_shift), 32'(m_shift));
    check("ccff_head", 32'(ccff_head), 32'(m_head));
    check("error", 32'(error), 32'(RB ? m_err : 1'b0));
  endtask

  task automatic cycle(input bit st, input bit ab, input bit v, input logic [NC-1:0] d);
    bit acc, apply;
    start = st; abort = ab; s_valid = v; s_data = d;
    acc = m_busy && v && !ab;
    @(posedge clk);
    #1;
    apply = m_err_pend;
    m_err_pend = 0;
    if (ab) begin
      m_busy = 0; m_done = 0; m_shift = 0; m_pass = 0; m_idx = 0;
    end else if (acc) begin
      m_head = d; m_shift = 1;
      if (m_pass == 0) m_first[m_idx] = d;
      else if (d != m_first[m_idx]) m_err_pend = 1;
      m_idx++;
      if (m_idx == LEN) begin
        m_idx = 0;
        if (RB && m_pass == 0) m_pass = 1;
        else begin m_busy = 0; m_done = 1; end
      end
    end else if (st && !m_busy) begin
      m_busy = 1; m_done = 0; m_pass = 0; m_idx = 0; m_shift = 0;
      m_err = 0; apply = 0;
    end else begin
      m_shift = 0;
    end
    if (apply) m_err = 1;
    check_all();
  endtask

  // dmode: 0 = 1..LEN, 1 = 0x3A5 constant, 2 = random. gmode: 0 back-to-back, 1 alternate, 2 random gaps + stray starts.
  task automatic run_load(input int dmode, input int gmode, input int flip_idx);
    logic [NC-1:0] seq [LEN];
    logic [NC-1:0] d;
    bit offer, st;
    int n, t;
    for (int i = 0; i < LEN; i++)
      seq[i] = (dmode == 0) ? NC'(i + 1) : (dmode == 1) ? 10'h3A5 : NC'($urandom);
    cycle(1, 0, 0, '0);
    for (int p = 0; p < (RB ? 2 : 1); p++) begin
      n = 0; t = 0;
      while (n < LEN) begin
        offer = (gmode == 0) ? 1'b1 : (gmode == 1) ? t[0] : ($urandom_range(0, 2) != 0);
        st    = (gmode == 2) && ($urandom_range(0, 5) == 0);
        d     = offer ? (seq[n] ^ ((p == 1 && n == flip_idx) ? 10'h008 : 10'h000)) : NC'($urandom);
        cycle(st, 0, offer, d);
        if (offer) n++;
        t++;
      end
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, NC'($urandom));
  endtask

  initial begin
    global_resetn = 0; start = 0; abort = 0; s_valid = 0; s_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    global_resetn = 1;

    for (int i = 0; i < 4; i++) cycle(0, 0, 1, NC'($urandom));

    run_load(0, 0, -1);
    run_load(0, 1, -1);
    for (int k = 0; k < 4; k++) run_load(2, 2, -1);
    run_load(1, 0, -1);
    run_load(1, 2, 4);
    cycle(0, 0, 0, '0);
    run_load(1, 0, -1);

    // Abort after three beats, then a complete reload from the start.
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, NC'(10'h0A1 + i));
    cycle(1, 1, 1, NC'($urandom));
    cycle(0, 0, 1, NC'($urandom));
    run_load(0, 0, -1);

    // Asynchronous reset in the middle of a load.
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, NC'($urandom));
    #2 global_resetn = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #3 global_resetn = 1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, NC'($urandom));
    run_load(2, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Writer side of the fabric configuration-chain (ccff) interface: streams a bitstream into NUM_CHAINS parallel ccff chains, one bit per chain per shift.
- Sits between the bitstream source (testbench or on-chip config controller) and fpga_top ccff_head/ccff_tail.
- Produces a registered head bit vector plus a one-cycle shift strobe used as the clock enable for the programming clock domain. Reports busy/done/error.

Parameters:
- NUM_CHAINS, 10, number of parallel configuration chains; width of s_data, ccff_head, ccff_tail.
- CHAIN_LEN, 1024, shifts per pass, equal to the length of the longest chain (shorter chains are pre-padded by the source).
- CNT_W, $clog2(CHAIN_LEN+1), shift counter width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- global_resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load sequence when idle.
- abort  input  1  returns to IDLE at the next edge from any state.
- s_valid  input  1  source has a beat on s_data.
- s_ready  output  1  loader accepts a beat this cycle.
- s_data  input  NUM_CHAINS  one bit per chain; bit i goes to chain i.
- ccff_head  output  NUM_CHAINS  registered head bits to fabric chains.
- ccff_shift  output  1  registered strobe; fabric shifts on the edge ending a cycle where this is 1.
- ccff_tail  input  NUM_CHAINS  chain tail bits from fabric.
- busy  output  1  high in LOAD/VERIFY.
- done  output  1  high in DONE.
- error  output  1  sticky readback mismatch flag; 0 when the optional feature is disabled.

Behaviour:
- Reset (global_resetn=0, asynchronous): state=IDLE, ccff_head=0, ccff_shift=0, s_ready=0, busy=0, done=0, error=0, count=0. Reset mid-load aborts immediately with no partial state retained.
- States: IDLE, LOAD, VERIFY (only with the feature), DONE.
- IDLE -> LOAD on start=1. count cleared; error cleared.
- LOAD and VERIFY:
  - s_ready=1 combinationally from state; handshake is s_valid&&s_ready.
  - Each accepted beat: next cycle ccff_head=s_data and ccff_shift=1.
  - A cycle with no beat: next cycle ccff_shift=0 and ccff_head holds.
  - Gaps of any length are legal; there is no timeout.
- count increments per accepted beat. On the beat that makes count==CHAIN_LEN:
  - LOAD -> VERIFY when the feature is enabled, otherwise -> DONE.
  - VERIFY -> DONE.
  - count reset to 0 on each state change.
- That last beat's ccff_shift pulse still appears one cycle after the transition. done rises in the same cycle as that final strobe.
- s_ready=0 in IDLE and DONE; beats offered there are not consumed.
- DONE: holds until start (-> LOAD, error cleared) or abort (-> IDLE).
- start while busy: ignored.
- abort: highest priority over start and handshake. At the next edge: state=IDLE, s_ready=0, ccff_shift=0, count=0. ccff_head holds its last value. error is unchanged.
- Latency: beat accepted at edge N is presented to the chain during cycle N+1 and captured by the fabric at edge N+1.
- ccff_shift is never asserted for more than CHAIN_LEN cycles per pass.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- Defined:
  - After LOAD, the loader enters VERIFY; the source re-streams the identical bitstream.
  - In every cycle with ccff_shift=1 during VERIFY, compare ccff_tail against ccff_head. The bit exiting the tail is the bit loaded at the same index in the first pass.
  - Any differing bit sets error (sticky until start or reset).
  - The chain holds the same configuration on exit.
- Not defined: no VERIFY state, LOAD -> DONE directly, error tied to 0, ccff_tail unused.

Test Plan:
- Reset then idle: with s_valid=1 and no start -> s_ready=0, ccff_shift=0, all outputs 0.
- CHAIN_LEN=8, start, 8 back-to-back beats 0x001..0x008 -> ccff_head shows 0x001..0x008 on 8 consecutive strobes, each one cycle after its accept. done=1 with the 8th strobe; a 9th beat is not accepted.
- Same load with s_valid toggling every other cycle -> exactly 8 strobes, in order, with no strobe on idle cycles.
- CCFF_READBACK_EN, CHAIN_LEN=8: load 0x3A5 x8, re-stream identical data (fabric model is a shift register) -> done=1, error=0. Repeat with the 5th verify beat flipped in bit 3 -> error=1 from the cycle after that strobe.
- abort after 3 beats -> next cycle IDLE, ccff_shift=0, busy=0, ccff_head holds the 3rd value. A new start then reloads all 8 from count 0.
- global_resetn pulsed low mid-LOAD (not aligned to clk) -> outputs 0 immediately. After release the state is IDLE and start is required to resume.
